// File: rtl/screen_xfer_pkg.sv
// Shared command/event codes, FSM states and read-latency helper for the screen PIO transfer controller.
package screen_xfer_pkg;

    localparam int unsigned CMD_W      = 3;
    localparam int unsigned EVT_W      = 3;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE   = 3'd0,
        CMD_START  = 3'd1,
        CMD_READ   = 3'd2,
        CMD_FINISH = 3'd3,
        CMD_ABORT  = 3'd4
    } cmd_e;

    typedef enum logic [EVT_W-1:0] {
        EVT_IDLE  = 3'd0,
        EVT_AVAIL = 3'd1,
        EVT_READY = 3'd2,
        EVT_DATA  = 3'd3,
        EVT_DONE  = 3'd4,
        EVT_ERROR = 3'd5
    } evt_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OFFER,
        S_READY,
        S_FETCH,
        S_ACK_WAIT,
        S_ERR_WAIT,
        S_TOUT
    } state_e;

    // Keeps the read-latency pipeline inside the supported 1..4 cycle range.
    function automatic int unsigned rd_lat_clamp(input int unsigned lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

    // Codes 5..7 carry no meaning and behave like NONE.
    function automatic cmd_e cmd_decode(input logic [CMD_W-1:0] raw);
        return (raw > 3'd4) ? CMD_NONE : cmd_e'(raw);
    endfunction

endpackage

// File: rtl/screen_xfer_cmd_sampler.sv
// Registers the Nios command/address PIOs and flags new commands (edge via NONE) and any change.
module screen_xfer_cmd_sampler
    import screen_xfer_pkg::*;
#(
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  nios_cmd,
    input  logic [ADDR_W-1:0] nios_addr,
    output cmd_e              cmd,
    output logic [ADDR_W-1:0] addr,
    output logic              cmd_new,
    output logic              cmd_chg,
    output logic              cmd_is_none
);

    cmd_e cmd_in_c;

    assign cmd_in_c = cmd_decode(nios_cmd);

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd         <= CMD_NONE;
            addr        <= '0;
            cmd_new     <= 1'b0;
            cmd_chg     <= 1'b0;
            cmd_is_none <= 1'b1;
        end else begin
            cmd         <= cmd_in_c;
            addr        <= nios_addr;
            cmd_chg     <= (cmd_in_c != cmd);
            cmd_new     <= (cmd_in_c != cmd) && (cmd_in_c != CMD_NONE);
            cmd_is_none <= (cmd_in_c == CMD_NONE);
        end
    end

endmodule

// File: rtl/screen_pio_xfer_ctrl.sv
// Four-phase PIO transfer of a locked screen frame to the Nios.
// Optional watchdog enabled by defining SCREEN_XFER_TIMEOUT_EN.
module screen_pio_xfer_ctrl
    import screen_xfer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FRAME_WORDS = 76800,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned TIMEOUT_CYC = 32'd16777216
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              frame_ready,
    output logic              fb_lock,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [DATA_W-1:0] fb_rd_data,
    input  logic [2:0]        nios_cmd,
    input  logic [ADDR_W-1:0] nios_addr,
    output logic [2:0]        nios_event,
    output logic [DATA_W-1:0] nios_data,
    output logic [ADDR_W-1:0] word_count,
    output logic [7:0]        overrun_cnt
);

    localparam int unsigned PIPE_LEN = rd_lat_clamp(RD_LATENCY);

    state_e              state, state_d;
    state_e              ack_next, ack_next_d;
    evt_e                evt_q, evt_d;
    logic                pending, pending_d;
    logic                abort_pend, abort_pend_d;
    logic                fb_lock_d, fb_rd_en_d;
    logic [ADDR_W-1:0]   fb_rd_addr_d, wc_d;
    logic [DATA_W-1:0]   data_d;
    logic [7:0]          ovr_d;
    logic [PIPE_LEN-1:0] rd_pipe;
    logic                go_abort_c, abort_now_c, rd_valid_c, tout_c;

    cmd_e                cmd;
    logic [ADDR_W-1:0]   addr_q;
    logic                cmd_new, cmd_chg, cmd_is_none;

    screen_xfer_cmd_sampler #(
        .ADDR_W (ADDR_W)
    ) u_sampler (
        .clk         (clk_clk),
        .reset       (reset_reset),
        .nios_cmd    (nios_cmd),
        .nios_addr   (nios_addr),
        .cmd         (cmd),
        .addr        (addr_q),
        .cmd_new     (cmd_new),
        .cmd_chg     (cmd_chg),
        .cmd_is_none (cmd_is_none)
    );

    assign nios_event  = evt_q;
    assign abort_now_c = cmd_new && (cmd == CMD_ABORT);
    assign rd_valid_c  = rd_pipe[PIPE_LEN-1];

`ifdef SCREEN_XFER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_armed_c;

    // Watchdog only runs while the FSM is waiting on the Nios and the command is static.
    assign wd_armed_c = (state != S_IDLE) && (state != S_FETCH) && (state != S_TOUT) && !cmd_chg;
    assign tout_c     = wd_armed_c && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_clk) begin
        if (reset_reset || !wd_armed_c || tout_c) wd_cnt <= '0;
        else                                      wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    logic unused_wdog;

    assign tout_c      = 1'b0;
    assign unused_wdog = cmd_chg | (TIMEOUT_CYC == 0);
`endif

    // Next-state, registered-output and pending/overrun decode.
    always_comb begin
        state_d      = state;
        ack_next_d   = ack_next;
        evt_d        = evt_q;
        abort_pend_d = abort_pend;
        fb_lock_d    = fb_lock;
        fb_rd_en_d   = 1'b0;
        fb_rd_addr_d = fb_rd_addr;
        data_d       = nios_data;
        wc_d         = word_count;
        pending_d    = pending;
        ovr_d        = overrun_cnt;
        go_abort_c   = 1'b0;

        case (state)
            S_IDLE: begin
                if (pending) begin
                    state_d   = S_OFFER;
                    evt_d     = EVT_AVAIL;
                    fb_lock_d = 1'b1;
                    wc_d      = '0;
                end
            end
            S_OFFER: begin
                if (abort_now_c) begin
                    go_abort_c = 1'b1;
                end else if (cmd_new && cmd == CMD_START) begin
                    state_d    = S_ACK_WAIT;
                    ack_next_d = S_READY;
                    evt_d      = EVT_READY;
                end
            end
            S_READY: begin
                if (abort_now_c) begin
                    go_abort_c = 1'b1;
                end else if (cmd_new && cmd == CMD_READ) begin
                    if (32'(addr_q) < FRAME_WORDS) begin
                        state_d      = S_FETCH;
                        fb_rd_en_d   = 1'b1;
                        fb_rd_addr_d = addr_q;
                    end else begin
                        state_d = S_ERR_WAIT;
                        evt_d   = EVT_ERROR;
                    end
                end else if (cmd_new && cmd == CMD_FINISH) begin
                    state_d    = S_ACK_WAIT;
                    ack_next_d = S_IDLE;
                    evt_d      = EVT_DONE;
                end
            end
            S_FETCH: begin
                // An abort arriving mid-read is remembered and honoured once the word is latched.
                if (abort_now_c) abort_pend_d = 1'b1;
                if (rd_valid_c) begin
                    data_d       = fb_rd_data;
                    abort_pend_d = 1'b0;
                    if (32'(word_count) < FRAME_WORDS) wc_d = word_count + ADDR_W'(1);
                    if (abort_pend || abort_now_c) begin
                        go_abort_c = 1'b1;
                    end else begin
                        state_d    = S_ACK_WAIT;
                        ack_next_d = S_READY;
                        evt_d      = EVT_DATA;
                    end
                end
            end
            S_ACK_WAIT: begin
                if (abort_now_c) begin
                    go_abort_c = 1'b1;
                end else if (cmd_is_none) begin
                    state_d = ack_next;
                    if (ack_next == S_IDLE) begin
                        fb_lock_d = 1'b0;
                        evt_d     = EVT_IDLE;
                    end else begin
                        evt_d = EVT_READY;
                    end
                end
            end
            S_ERR_WAIT: begin
                if (abort_now_c) begin
                    go_abort_c = 1'b1;
                end else if (cmd_is_none) begin
                    state_d = S_READY;
                    evt_d   = EVT_READY;
                end
            end
            S_TOUT: begin
                state_d = S_IDLE;
                evt_d   = EVT_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_abort_c) begin
            state_d    = S_ACK_WAIT;
            ack_next_d = S_IDLE;
            evt_d      = EVT_ERROR;
            fb_lock_d  = 1'b0;
        end

        if (tout_c) begin
            state_d      = S_TOUT;
            evt_d        = EVT_ERROR;
            fb_lock_d    = 1'b0;
            abort_pend_d = 1'b0;
        end

        // A frame finishing while one is already queued is lost and counted.
        if (state == S_IDLE) begin
            pending_d = pending ? 1'b0 : frame_ready;
        end else if (frame_ready) begin
            if (!pending)                   pending_d = 1'b1;
            else if (overrun_cnt != 8'hFF)  ovr_d     = overrun_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= S_IDLE;
            ack_next    <= S_IDLE;
            evt_q       <= EVT_IDLE;
            pending     <= 1'b0;
            abort_pend  <= 1'b0;
            fb_lock     <= 1'b0;
            fb_rd_en    <= 1'b0;
            fb_rd_addr  <= '0;
            nios_data   <= '0;
            word_count  <= '0;
            overrun_cnt <= '0;
            rd_pipe     <= '0;
        end else begin
            state       <= state_d;
            ack_next    <= ack_next_d;
            evt_q       <= evt_d;
            pending     <= pending_d;
            abort_pend  <= abort_pend_d;
            fb_lock     <= fb_lock_d;
            fb_rd_en    <= fb_rd_en_d;
            fb_rd_addr  <= fb_rd_addr_d;
            nios_data   <= data_d;
            word_count  <= wc_d;
            overrun_cnt <= ovr_d;
            rd_pipe     <= (rd_pipe << 1) | PIPE_LEN'(fb_rd_en);
        end
    end

endmodule
